// File: rtl/pmu_pkg.sv
// Shared types and register map for the speed-request initiator.
package pmu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] OFS_SPEED  = 8'd0;
  localparam logic [7:0] OFS_STATUS = 8'd1;
  localparam logic [7:0] OFS_CTRL   = 8'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_PENDING = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_OVERRUN = 3;

  // Counter must hold the larger of the two timed-state lengths minus one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pmu_down_counter.sv
// Loadable down counter that saturates at zero; shared by both timed states.
module pmu_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pmu_speed_requester.sv
// CPU-side initiator: turns SPEED writes into a timed change pulse plus settle window.
module pmu_speed_requester
  import pmu_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = 8'h40,
  parameter int         PULSE_CYCLES  = 4,
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [7:0] RESET_VECTOR  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       change,
  output logic [7:0] change_vector,
  output logic       busy,
  output logic       irq
);

  localparam int CW = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  localparam logic [7:0] ADDR_SPEED  = BASE_ADDR + OFS_SPEED;
  localparam logic [7:0] ADDR_STATUS = BASE_ADDR + OFS_STATUS;
  localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + OFS_CTRL;

  state_t        state, next_state;
  logic          pending, done, overrun, irq_en;
  logic [7:0]    pending_code;
  logic          ctr_load, ctr_en, ctr_zero;
  logic [CW-1:0] ctr_load_value;
  logic          launch, set_done;
  logic [7:0]    launch_code;

  logic speed_wr, ctrl_wr, status_rd, store_pending, set_overrun;

  assign speed_wr  = io_wr && (io_addr == ADDR_SPEED);
  assign ctrl_wr   = io_wr && (io_addr == ADDR_CTRL);
  assign status_rd = io_rd && (io_addr == ADDR_STATUS);

  // While a pending code is being launched from IDLE, a new write simply
  // refills the slot; it only counts as an overrun when a request is in flight.
  assign store_pending = speed_wr && (state != IDLE || pending);
  assign set_overrun   = store_pending && pending && (state != IDLE);

  pmu_down_counter #(.W(CW)) u_counter (
    .clk        (clk),
    .rst_n      (reset),
    .load       (ctr_load),
    .load_value (ctr_load_value),
    .enable     (ctr_en),
    .zero       (ctr_zero)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state     = state;
    ctr_load       = 1'b0;
    ctr_load_value = PULSE_LOAD;
    ctr_en         = 1'b0;
    launch         = 1'b0;
    launch_code    = io_wdata;
    set_done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending) begin
          launch      = 1'b1;
          launch_code = pending_code;
          ctr_load    = 1'b1;
          next_state  = ASSERT;
        end else if (speed_wr) begin
          if (io_wdata == change_vector) begin
            set_done = 1'b1;
          end else begin
            launch     = 1'b1;
            ctr_load   = 1'b1;
            next_state = ASSERT;
          end
        end
      end
      ASSERT: begin
        ctr_en = 1'b1;
        if (ctr_zero) begin
          ctr_load       = 1'b1;
          ctr_load_value = SETTLE_LOAD;
          next_state     = SETTLE;
        end
      end
      SETTLE: begin
        ctr_en = 1'b1;
        if (ctr_zero) begin
          set_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      change_vector <= RESET_VECTOR;
      pending       <= 1'b0;
      pending_code  <= '0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      irq_en        <= 1'b0;
    end else begin
      state <= next_state;
      if (launch) change_vector <= launch_code;

      if (store_pending) begin
        pending      <= 1'b1;
        pending_code <= io_wdata;
      end else if (launch) begin
        pending <= 1'b0;
      end

      // Setting has priority over a same-edge STATUS read.
      if (set_done)       done <= 1'b1;
      else if (status_rd) done <= 1'b0;

      if (set_overrun)    overrun <= 1'b1;
      else if (status_rd) overrun <= 1'b0;

      if (ctrl_wr) irq_en <= io_wdata[0];
    end
  end

  assign change = (state == ASSERT);
  assign busy   = (state != IDLE);
  assign irq    = done && irq_en;

  always_comb begin
    io_rdata = 8'h00;
    if (io_addr == ADDR_SPEED) begin
      io_rdata = change_vector;
    end else if (io_addr == ADDR_STATUS) begin
      io_rdata[ST_BUSY]    = busy;
      io_rdata[ST_PENDING] = pending;
      io_rdata[ST_DONE]    = done;
      io_rdata[ST_OVERRUN] = overrun;
    end else if (io_addr == ADDR_CTRL) begin
      io_rdata[0] = irq_en;
    end
  end

endmodule
